// File: rtl/grid_io_multi.sv
// rtl/grid_io_multi.sv - multi-pad perimeter I/O tile with ccff configuration chain
//
// Purpose:
//   NUM_PADS GPIO pads per tile. Each pad takes 3 configuration bits from the
//   tile's segment of the ccff chain: oe (bit 3p), ireg (bit 3p+1) and
//   oreg (bit 3p+2). A saturating bit counter flags a fully loaded segment.
//
// Optional feature macro: GRID_IO_SHADOW_CFG_EN
//   When defined, adds ccff_load and a shadow register. Pad modes are decoded
//   from the shadow copy, so the pads do not change while the chain shifts.
//
// Ports:
//   prog_clk           - clock for the chain, counter and pad registers
//   pReset             - synchronous active-high reset
//   ccff_en            - chain shift enable
//   ccff_head          - serial configuration in
//   ccff_load          - copy chain into shadow register (macro builds only)
//   ccff_tail          - serial configuration out (last chain bit)
//   cfg_loaded         - high once NUM_PADS*3 bits have shifted since reset
//   gfpga_pad_GPIO_PAD - physical pads (tri-state)
//   outpad             - fabric data to drive onto the pads
//   inpad              - pad data to the fabric
module grid_io_multi #(
  parameter int NUM_PADS = 4
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                ccff_en,
  input  logic                ccff_head,
`ifdef GRID_IO_SHADOW_CFG_EN
  input  logic                ccff_load,
`endif
  output logic                ccff_tail,
  output logic                cfg_loaded,
  inout  wire  [NUM_PADS-1:0] gfpga_pad_GPIO_PAD,
  input  logic [NUM_PADS-1:0] outpad,
  output logic [NUM_PADS-1:0] inpad
);

  localparam int CFG_W = 3;
  localparam int L     = NUM_PADS * CFG_W;
  localparam int CNT_W = $clog2(L + 1);

  logic [L-1:0]        r_sr;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_cfg_loaded;
  logic                r_rst_q;
  logic [NUM_PADS-1:0] r_oq;
  logic [NUM_PADS-1:0] r_iq;

  logic [CNT_W-1:0]    w_cnt_next;
  logic [L-1:0]        w_cfg;
  logic                w_block;
  logic [NUM_PADS-1:0] w_oe;
  logic [NUM_PADS-1:0] w_dout;
  logic [NUM_PADS-1:0] w_pad_in;

  assign w_pad_in = gfpga_pad_GPIO_PAD;

  // Saturating shift counter
  always_comb begin
    w_cnt_next = r_cnt;
    if (ccff_en && (r_cnt != CNT_W'(L))) begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      r_sr         <= '0;
      r_cnt        <= '0;
      r_cfg_loaded <= 1'b0;
      r_oq         <= '0;
      r_iq         <= '0;
      r_rst_q      <= 1'b1;
    end else begin
      if (ccff_en) begin
        r_sr <= {r_sr[L-2:0], ccff_head};
      end
      r_cnt        <= w_cnt_next;
      // Looks at the post-edge count so the flag rises together with cnt==L
      r_cfg_loaded <= (w_cnt_next == CNT_W'(L));
      r_oq         <= outpad;
      r_iq         <= w_pad_in;
      r_rst_q      <= 1'b0;
    end
  end

`ifdef GRID_IO_SHADOW_CFG_EN
  logic [L-1:0] r_sh;

  // Nonblocking capture takes the pre-shift chain when load and shift coincide
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      r_sh <= '0;
    end else if (ccff_load) begin
      r_sh <= r_sr;
    end
  end

  assign w_cfg = r_sh;
`else
  assign w_cfg = r_sr;
`endif

  assign ccff_tail  = r_sr[L-1];
  assign cfg_loaded = r_cfg_loaded;

  // Pads stay released and inpad stays quiet during reset and the first
  // cycle after it, whatever the pad pins are doing.
  assign w_block = pReset | r_rst_q;

  always_comb begin
    w_oe   = '0;
    w_dout = '0;
    inpad  = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      w_oe[p]   = w_cfg[CFG_W*p] & ~w_block;
      w_dout[p] = w_cfg[CFG_W*p+2] ? r_oq[p] : outpad[p];
      if (!w_block && !w_oe[p]) begin
        inpad[p] = w_cfg[CFG_W*p+1] ? r_iq[p] : w_pad_in[p];
      end
    end
  end

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    assign gfpga_pad_GPIO_PAD[p] = w_oe[p] ? w_dout[p] : 1'bz;
  end

endmodule
